// File: rtl/fp_adder_arbiter_if.sv
// Requester, adder and result handshake bundle for fp_adder_arbiter.
// The master modport is the arbiter side, the slave modport is its environment.
interface fp_adder_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    Req_valid;
    logic [N_REQ*64-1:0] Req_A;
    logic [N_REQ*64-1:0] Req_B;
    logic [N_REQ-1:0]    Req_ready;

    logic [63:0] Adder_A;
    logic [63:0] Adder_B;
    logic        Adder_A_store_bit;
    logic        Adder_B_store_bit;
    logic        Adder_A_acknowledgment;
    logic        Adder_B_acknowledgment;
    logic [63:0] Adder_SUM;
    logic        Adder_SUM_store_bit;
    logic        Adder_SUM_acknowledgment;

    logic [63:0]   Result_SUM;
    logic [IW-1:0] Result_id;
    logic          Result_error;
    logic          Result_valid;
    logic          Result_ready;
    logic          Timeout_flag;

    modport master (
        input  Req_valid, Req_A, Req_B,
        output Req_ready,
        output Adder_A, Adder_B,
        output Adder_A_store_bit, Adder_B_store_bit,
        input  Adder_A_acknowledgment, Adder_B_acknowledgment,
        input  Adder_SUM, Adder_SUM_store_bit,
        output Adder_SUM_acknowledgment,
        output Result_SUM, Result_id, Result_error, Result_valid,
        input  Result_ready,
        output Timeout_flag
    );

    modport slave (
        output Req_valid, Req_A, Req_B,
        input  Req_ready,
        input  Adder_A, Adder_B,
        input  Adder_A_store_bit, Adder_B_store_bit,
        output Adder_A_acknowledgment, Adder_B_acknowledgment,
        output Adder_SUM, Adder_SUM_store_bit,
        input  Adder_SUM_acknowledgment,
        input  Result_SUM, Result_id, Result_error, Result_valid,
        output Result_ready,
        input  Timeout_flag
    );
endinterface

// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter sequencing one shared double-precision adder
// among N_REQ requesters, with a per-state watchdog abort.
module fp_adder_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input logic Clock,
    input logic Reset,
    fp_adder_arbiter_if.master bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SEND_A   = 3'd1;
    localparam logic [2:0] SEND_B   = 3'd2;
    localparam logic [2:0] WAIT_SUM = 3'd3;
    localparam logic [2:0] RESULT   = 3'd4;

    localparam logic [63:0] QNAN = 64'hFFF8000000000000;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    win;
    logic             found;
    logic [N_REQ-1:0] grant;
    logic             fire;
    logic [63:0]      sel_a;
    logic [63:0]      sel_b;
    logic [CW-1:0]    cnt;
    logic             expired;
    logic             waiting;
    logic             abort;
    logic [63:0]      op_a;
    logic [63:0]      op_b;
    logic [63:0]      sum_q;
    logic [IW-1:0]    id_q;
    logic             err_q;
    logic             flag_q;

    // Indices above last_grant beat those at or below it; lowest index
    // wins within each group, which is the wrapped search order.
    always_comb begin
        win   = '0;
        found = |bus.Req_valid;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.Req_valid[i] && IW'(i) <= last_grant) win = IW'(i);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.Req_valid[i] && IW'(i) > last_grant) win = IW'(i);
        end
    end

    always_comb begin
        grant = '0;
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IW'(i) == win) begin
                grant[i] = found && (state == IDLE);
                sel_a    = bus.Req_A[64*i +: 64];
                sel_b    = bus.Req_B[64*i +: 64];
            end
        end
    end

    assign fire    = |(bus.Req_valid & grant);
    assign expired = (cnt == CW'(TIMEOUT - 1));
    assign waiting = (state == SEND_A) || (state == SEND_B) ||
                     (state == WAIT_SUM);

    // A handshake on the expiry edge still wins over the abort.
    always_comb begin
        state_next = state;
        abort      = 1'b0;
        case (state)
            IDLE:
                if (fire) state_next = SEND_A;
            SEND_A:
                if (bus.Adder_A_acknowledgment) state_next = SEND_B;
                else if (expired) abort = 1'b1;
            SEND_B:
                if (bus.Adder_B_acknowledgment) state_next = WAIT_SUM;
                else if (expired) abort = 1'b1;
            WAIT_SUM:
                if (bus.Adder_SUM_store_bit) state_next = RESULT;
                else if (expired) abort = 1'b1;
            RESULT:
                if (bus.Result_ready) state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
        if (abort) state_next = RESULT;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            last_grant <= IW'(N_REQ - 1);
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            sum_q      <= '0;
            id_q       <= '0;
            err_q      <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) cnt <= '0;
            else if (waiting) cnt <= cnt + CW'(1);
            if (fire) begin
                op_a       <= sel_a;
                op_b       <= sel_b;
                id_q       <= win;
                last_grant <= win;
            end
            if (state == WAIT_SUM && bus.Adder_SUM_store_bit) begin
                sum_q <= bus.Adder_SUM;
                err_q <= 1'b0;
            end
            if (abort) begin
                sum_q  <= QNAN;
                err_q  <= 1'b1;
                flag_q <= 1'b1;
            end
        end
    end

    assign bus.Req_ready                = grant;
    assign bus.Adder_A                  = op_a;
    assign bus.Adder_B                  = op_b;
    assign bus.Adder_A_store_bit        = (state == SEND_A);
    assign bus.Adder_B_store_bit        = (state == SEND_B);
    assign bus.Adder_SUM_acknowledgment = (state == WAIT_SUM);
    assign bus.Result_valid             = (state == RESULT);
    assign bus.Result_SUM               = sum_q;
    assign bus.Result_id                = id_q;
    assign bus.Result_error             = err_q;
    assign bus.Timeout_flag             = flag_q;
endmodule

// File: doc/fp_adder_arbiter.md
# fp_adder_arbiter

Round-robin arbiter and sequencer that shares one `Floating_Point_Adder` instance among `N_REQ` requesters. It accepts an operand pair from the winning requester and drives the adder's A, B and SUM store/acknowledgment handshakes in order. It returns the 64-bit IEEE-754 double result tagged with the requester index. A watchdog aborts a transaction if the adder stalls.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 1024, max cycles spent in any one adder-handshake state before abort (≥2)
- `Clock`  in  1  single clock, rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `Req_valid`  in  N_REQ  requester i has an operand pair pending
- `Req_A`, `Req_B`  in  N_REQ*64  operand pairs; requester i at bits [64i+63:64i]
- `Req_ready`  out  N_REQ  one-hot grant; transfer when `Req_valid[i] && Req_ready[i]` at an edge
- `Adder_A`, `Adder_B`  out  64  latched operands to the adder
- `Adder_A_store_bit`, `Adder_B_store_bit`  out  1  operand offered to the adder
- `Adder_A_acknowledgment`, `Adder_B_acknowledgment`  in  1  adder ready for that operand
- `Adder_SUM`  in  64  adder result
- `Adder_SUM_store_bit`  in  1  adder result valid
- `Adder_SUM_acknowledgment`  out  1  arbiter ready to take the result
- `Result_SUM`  out  64  result to the requester
- `Result_id`  out  $clog2(N_REQ)  index of the owning requester
- `Result_error`  out  1  result produced by a watchdog abort
- `Result_valid`  out  1  result pending
- `Result_ready`  in  1  downstream consumer accepts the result
- `Timeout_flag`  out  1  sticky; set on any abort, cleared only by `Reset`

## Operation
- FSM states: IDLE, SEND_A, SEND_B, WAIT_SUM, RESULT.
- **IDLE**
  - `Req_ready` is a combinational one-hot, driven from `Req_valid` and the pointer `Last_grant`.
  - The winner is the first i with `Req_valid[i]` high, searching from `Last_grant+1` modulo N_REQ.
  - On the transfer edge: latch A, B and id; set `Last_grant`=id; move to SEND_A.
  - With no valid requester, `Req_ready`=0 and the FSM stays in IDLE.
- **SEND_A**
  - `Adder_A_store_bit`=1.
  - At an edge where `Adder_A_acknowledgment`=1: move to SEND_B.
- **SEND_B**
  - `Adder_B_store_bit`=1.
  - At an edge where `Adder_B_acknowledgment`=1: move to WAIT_SUM.
- **WAIT_SUM**
  - `Adder_SUM_acknowledgment`=1.
  - At an edge where `Adder_SUM_store_bit`=1: latch `Adder_SUM` into `Result_SUM`, clear `Result_error`, move to RESULT.
- **RESULT**
  - `Result_valid`=1, `Result_id` holds the latched id.
  - At an edge where `Result_ready`=1: move to IDLE.
- **Outputs**
  - `Adder_A` and `Adder_B` are held constant from the capture edge until the next capture.
  - `Req_ready`=0 in every state except IDLE. There is at most one outstanding transaction.
- **Watchdog**
  - Counter is cleared on every state change.
  - Counter increments each cycle in SEND_A, SEND_B and WAIT_SUM.
  - When the counter reaches TIMEOUT-1 without the awaited handshake:
    - `Result_SUM`=64'hFFF8000000000000 (quiet NaN);
    - `Result_error`=1;
    - `Timeout_flag`=1;
    - move to RESULT.
  - A handshake arriving on that same edge takes priority over the abort.
- **Fairness:** the requester granted last has the lowest priority next time. A single requester asserting continuously is granted every transaction.

## Timing
- **Reset values:**
  - state IDLE; `Last_grant`=N_REQ-1, so requester 0 wins the first arbitration;
  - counter 0;
  - all handshake outputs, `Result_valid`, `Result_error`, `Timeout_flag` = 0;
  - `Adder_A`, `Adder_B`, `Result_SUM` = 0; `Result_id` = 0.
- The handshake outputs (`*_store_bit`, `Adder_SUM_acknowledgment`, `Result_valid`) are decoded from the registered state. No combinational path exists from adder inputs to adder outputs.
- **Latency** with acks always high, capture at edge 0:
  - `Adder_A_store_bit` high in cycle 1; A transfers at edge 1.
  - B transfers at edge 2.
  - The SUM handshake is open from cycle 3.
  - `Result_valid` rises one cycle after the SUM transfer edge.
- **Throughput:** the next grant is possible in the cycle after the `Result_ready` edge. That is ≥5 cycles plus adder latency per transaction.
- **Reset mid-transaction:** the FSM returns to IDLE immediately and asynchronously; the in-flight result is discarded. The adder shares `Reset` and is flushed together with the arbiter.
- `Req_valid` may drop while not granted; no operand is captured in that case.

## Test plan
- Reset, then Req_valid=4'b0001, A=0x3FF0000000000000 (1.0), B=0x4000000000000000 (2.0); adder model acks after 2 cycles -> `Req_ready[0]` pulses; `Result_SUM`=0x4008000000000000, `Result_id`=0, `Result_error`=0.
- Req_valid=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3; each `Result_id` matches its grant.
- Req_valid=4'b0100 continuously -> requester 2 is granted every transaction, with a gap of exactly 1 idle cycle after each `Result_ready`.
- Adder never asserts `Adder_B_acknowledgment`, TIMEOUT=16 -> abort 15 cycles after SEND_B entry; `Result_SUM`=0xFFF8000000000000, `Result_error`=1, `Timeout_flag` stays 1 through the next good transaction.
- `Result_ready` held low for 10 cycles in RESULT -> `Result_valid` and data stay stable; `Req_ready` stays 0 for all requesters.
- `Reset` asserted during WAIT_SUM -> outputs are at their reset values within the same cycle; the next transaction grants requester 0 and completes correctly.
